// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : stack_unit
// Description : Parameterised LIFO stack with push, pop, peek (tos),
//               replace-top and empty-bypass, plus sticky overflow and
//               underflow flags. Storage itself is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     tos,
  input  logic [WIDTH-1:0]         d_in,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         d_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     unf
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     SP_ONE   = (AW+1)'(1);
  localparam logic [AW:0]     SP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   IDX_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_top;
  logic             w_replace;

  // Occupancy flags come straight from the stack pointer.
  assign full      = (sp_q == SP_DEPTH);
  assign empty     = (sp_q == '0);
  assign count     = sp_q;
  assign d_out     = dout_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  // Top entry sits one below the next-free slot; the index is only used when not empty.
  assign w_top_idx = sp_q[AW-1:0] - IDX_ONE;
  assign w_top     = mem_q[w_top_idx];

  // Push together with pop (or with tos when pop is absent) swaps the top entry.
  assign w_replace = push & (pop | tos);

  // Next-state decode: one operation per cycle, priority replace > pop > push > tos.
  always_comb begin
    sp_d    = sp_q;
    dout_d  = dout_q;
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;
    w_we    = 1'b0;
    w_waddr = sp_q[AW-1:0];
    if (w_replace) begin
      if (empty) begin
        dout_d = d_in;
      end else begin
        dout_d  = w_top;
        w_we    = 1'b1;
        w_waddr = w_top_idx;
      end
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        dout_d = w_top;
        sp_d   = sp_q - SP_ONE;
      end
    end else if (push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        w_we = 1'b1;
        sp_d = sp_q + SP_ONE;
      end
    end else if (tos) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        dout_d = w_top;
      end
    end
  end

  // Control state: pointer, read register and sticky flags, async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage array: no reset, writes suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      mem_q[w_waddr] <= d_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_unit
// Description : Scoreboard bench for stack_unit against a queue-based
//               LIFO reference model; directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             push, pop, tos, clr_err;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic [AW:0]      count;
  logic             full, empty, ovf, unf;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .tos     (tos),
    .d_in    (d_in),
    .clr_err (clr_err),
    .d_out   (d_out),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dout;
    int cnt;
    int fl;
    int em;
    int ov;
    int un;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_stk[$];
  int m_dout;
  bit m_ovf, m_unf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_stk.delete();
    m_dout = 0;
    m_ovf  = 0;
    m_unf  = 0;
  endfunction

  // Stack semantics written directly from the operation rules.
  function automatic void model_step(input bit pu, input bit po, input bit to,
                                     input int d, input bit ce);
    bit eo = 0;
    bit eu = 0;
    int n  = m_stk.size();
    if (pu && (po || to)) begin
      if (n == 0) m_dout = d;
      else begin
        m_dout         = m_stk[n-1];
        m_stk[n-1]     = d;
      end
    end else if (po) begin
      if (n == 0) eu = 1;
      else m_dout = m_stk.pop_back();
    end else if (pu) begin
      if (n == DEPTH) eo = 1;
      else m_stk.push_back(d);
    end else if (to) begin
      if (n == 0) eu = 1;
      else m_dout = m_stk[n-1];
    end
    if (ce) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (eo) m_ovf = 1;
    if (eu) m_unf = 1;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.dout = m_dout;
    e.cnt  = m_stk.size();
    e.fl   = (m_stk.size() == DEPTH) ? 1 : 0;
    e.em   = (m_stk.size() == 0) ? 1 : 0;
    e.ov   = m_ovf ? 1 : 0;
    e.un   = m_unf ? 1 : 0;
    sb.push_back(e);
  endfunction

  task automatic cyc(input bit pu, input bit po, input bit to,
                     input logic [7:0] d, input bit ce);
    @(negedge clk);
    rst = 1'b0; push = pu; pop = po; tos = to; d_in = d; clr_err = ce;
    model_step(pu, po, to, int'(d), ce);
    push_exp();
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    rst = 1'b1;
    push = 1'($urandom); pop = 1'($urandom); tos = 1'($urandom);
    d_in = 8'($urandom); clr_err = 1'($urandom);
    model_reset();
    push_exp();
  endtask

  // Monitor: results are registered, so one expectation per active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("d_out", 32'(d_out), 32'(e.dout));
        chk("count", 32'(count), 32'(e.cnt));
        chk("full",  32'(full),  32'(e.fl));
        chk("empty", 32'(empty), 32'(e.em));
        chk("ovf",   32'(ovf),   32'(e.ov));
        chk("unf",   32'(unf),   32'(e.un));
      end
    end
  end

  initial begin
    int pth;
    rst = 1'b1; push = 0; pop = 0; tos = 0; d_in = 0; clr_err = 0;
    model_reset();
    rst_cyc();

    // LIFO ordering
    cyc(1, 0, 0, 8'h11, 0);
    cyc(1, 0, 0, 8'h22, 0);
    cyc(1, 0, 0, 8'h33, 0);
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 1, 0, 8'h00, 0);

    // Fill, overflow, pop returns last accepted value
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 8'(8'hA0 + i), 0);
    cyc(1, 0, 0, 8'hAA, 0);
    cyc(0, 1, 0, 8'h00, 0);
    // Replace-top while full must not set overflow again after clear
    cyc(0, 0, 0, 8'h00, 1);
    cyc(1, 0, 0, 8'h5A, 0);
    cyc(1, 1, 0, 8'h6B, 0);
    rst_cyc();

    // Underflow from reset, clear, clear racing a new underflow
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 1, 0, 8'h00, 1);
    cyc(0, 0, 1, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);

    // Replace-top, peek, bypass on empty, tos+push and tos+pop
    cyc(1, 0, 0, 8'h05, 0);
    cyc(1, 1, 0, 8'h09, 0);
    cyc(0, 0, 1, 8'h00, 0);
    cyc(1, 0, 1, 8'h3C, 0);
    cyc(0, 1, 1, 8'h00, 0);
    cyc(1, 1, 0, 8'h7E, 0);
    cyc(1, 0, 1, 8'h4D, 0);

    // Asynchronous reset between edges while a push is pending
    cyc(1, 0, 0, 8'h01, 0);
    cyc(1, 0, 0, 8'h02, 0);
    cyc(1, 0, 0, 8'h03, 0);
    @(negedge clk);
    push = 1; pop = 0; tos = 0; d_in = 8'h99; clr_err = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_full",  32'(full),  32'd0);
    chk("async_rst_dout",  32'(d_out), 32'd0);
    model_reset();
    push_exp();
    cyc(1, 0, 0, 8'h44, 0);
    cyc(0, 1, 0, 8'h00, 0);

    // Random traffic: push-heavy phase then pop-heavy phase
    for (int i = 0; i < 800; i++) begin
      pth = (i < 400) ? 65 : 30;
      if ($urandom_range(0, 99) == 0) rst_cyc();
      else cyc(($urandom_range(0, 99) < pth), ($urandom_range(0, 99) < 35),
               ($urandom_range(0, 99) < 20), 8'($urandom), ($urandom_range(0, 99) < 8));
    end

    @(negedge clk);
    push = 0; pop = 0; tos = 0; clr_err = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
